// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared I2C target/master FSM states and bus constants
// Rev 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ACK_ADDR = 4'd2,
    ST_PTR      = 4'd3,
    ST_ACK_PTR  = 4'd4,
    ST_WR       = 4'd5,
    ST_ACK_WR   = 4'd6,
    ST_RD       = 4'd7,
    ST_RACK     = 4'd8,
    ST_WAIT     = 4'd9
  } i2c_state_t;

  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;
  localparam int   BIT_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// i2c_sync_edge : 2-FF synchronizer plus history FF with rise/fall detect
// Rev 1.0
// ============================================================================
module i2c_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, hist_q;
  logic meta_d, sync_d, hist_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// i2c_target : 7-bit-address I2C target with auto-incrementing byte pointer
// Rev 1.0
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         PTR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             rd_stb,
  output logic             busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (.clk(clk), .reset(reset), .din(scl),
                            .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda_sync (.clk(clk), .reset(reset), .din(sda),
                            .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  i2c_state_t           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 full_q, full_d;
  logic [7:0]           shift_q, shift_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 rack_q, rack_d;
  logic                 busy_q, busy_d;
  logic                 load_rd;
  logic                 start_det, stop_det, rx_state;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WR);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    full_d    = full_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    rack_d    = rack_q;
    busy_d    = busy_q;
    load_rd   = 1'b0;

    // Bus conditions outrank bit processing; busy survives a repeated START.
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (scl_rise) begin
        if (rx_state) begin
          shift_d   = {shift_q[6:0], sda_lvl};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (&bit_cnt_q) full_d = 1'b1;
        end
        if (state_q == ST_RACK) rack_d = sda_lvl;
      end

      if (scl_fall) begin
        case (state_q)
          ST_ADDR: if (full_q) begin
            full_d = 1'b0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d  = ST_ACK_ADDR;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
              busy_d  = 1'b0;
            end
          end
          ST_ACK_ADDR: begin
            sda_oe_d = 1'b0;
            if (shift_q[0]) load_rd = 1'b1;
            else            state_d = ST_PTR;
          end
          ST_PTR: if (full_q) begin
            full_d   = 1'b0;
            ptr_d    = PTR_W'(shift_q);
            sda_oe_d = 1'b1;
            state_d  = ST_ACK_PTR;
          end
          ST_ACK_PTR, ST_ACK_WR: begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR;
          end
          ST_WR: if (full_q) begin
            full_d    = 1'b0;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_q + PTR_W'(1);
            sda_oe_d  = 1'b1;
            state_d   = ST_ACK_WR;
          end
          ST_RD: begin
            if (&bit_cnt_q) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
          ST_RACK: begin
            if (rack_q == ACK) load_rd = 1'b1;
            else begin
              state_d = ST_WAIT;
              busy_d  = 1'b0;
            end
          end
          default: ;
        endcase

        // Fetch the next transmit byte and present its MSB.
        if (load_rd) begin
          shift_d   = rd_data;
          rd_stb_d  = 1'b1;
          ptr_d     = ptr_q + PTR_W'(1);
          sda_oe_d  = ~rd_data[7];
          bit_cnt_d = '0;
          state_d   = ST_RD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      full_q    <= 1'b0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_stb_q  <= 1'b0;
      rack_q    <= NACK;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      full_q    <= full_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      rack_q    <= rack_d;
      busy_q    <= busy_d;
    end
  end

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign rd_stb  = rd_stb_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// tb_i2c_target : bit-banged I2C master driving i2c_target against a byte model
// Rev 1.0
// ============================================================================
module tb_i2c_target;

  localparam int Q = 5;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       wr_stb, rd_stb, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h50), .PTR_W(8)) dut (
    .clk(clk), .reset(reset), .scl(scl_m), .sda(sda),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_stb(rd_stb), .busy(busy)
  );

  // Register fabric: contents start as addr^0xFF, read data lags rd_addr by 1 clk.
  logic [7:0]  fab [256];
  logic        fab_ready = 1'b0;
  logic [15:0] wr_log [1024];
  int          wr_n = 0, rd_n = 0, drove_n = 0, busy_n = 0;

  always @(posedge clk) begin
    if (!fab_ready) begin
      for (int i = 0; i < 256; i++) fab[i] <= 8'(i) ^ 8'hFF;
      fab_ready <= 1'b1;
    end else if (wr_stb) begin
      fab[wr_addr] <= wr_data;
    end
    if (wr_stb) begin
      wr_log[wr_n] <= {wr_addr, wr_data};
      wr_n         <= wr_n + 1;
    end
    if (rd_stb) rd_n <= rd_n + 1;
    if (!m_low && sda === 1'b0) drove_n <= drove_n + 1;
    if (busy) busy_n <= busy_n + 1;
    rd_data <= fab[rd_addr];
  end

  int         checks = 0, errors = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr = 8'h00;
  int         wr_exp = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_bit(input logic b);
    int su;
    su = $urandom_range(6, 2);
    tick(8 - su);
    m_low = ~b;
    tick(su);
    scl_m = 1'b1;
    tick(10);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    tick(2);
    m_low = 1'b0;
    tick(6);
    scl_m = 1'b1;
    tick(5);
    b = (sda !== 1'b0);
    tick(5);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    tick(2);
    m_low = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(2);
    m_low = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    m_low = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
    write_bit(mack);
  endtask

  // Model: address byte then pointer byte, each must be ACKed.
  task automatic set_ptr(input logic [7:0] p, input string tag);
    logic ack;
    send_byte(8'hA0, ack);
    check({tag, "_addr_ack"}, ack, 1'b0);
    send_byte(p, ack);
    check({tag, "_ptr_ack"}, ack, 1'b0);
    m_ptr = p;
  endtask

  // Model: a data byte lands at the pointer, then the pointer wraps forward.
  task automatic write_data(input logic [7:0] d, input string tag);
    logic ack;
    send_byte(d, ack);
    check({tag, "_data_ack"}, ack, 1'b0);
    wr_exp++;
    check({tag, "_wr_count"}, wr_n, wr_exp);
    check({tag, "_wr_entry"}, wr_log[wr_exp-1], {m_ptr, d});
    m_mem[m_ptr] = d;
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic read_data(input logic last, input string tag);
    logic [7:0] b;
    read_byte(b, last);
    check({tag, "_rd_byte"}, b, m_mem[m_ptr]);
    m_ptr = m_ptr + 8'd1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] p, d;
    int         n, k, s_wr, s_rd, s_dr, s_bz;

    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'hFF;

    tick(5);
    check("rst_rd_addr", rd_addr, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_rd_stb", rd_stb, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_sda", sda, 1'b1);
    reset = 1'b0;
    tick(5);

    // Directed write of two bytes starting at 0x10.
    bus_start();
    set_ptr(8'h10, "w");
    check("w_busy", busy, 1'b1);
    write_data(8'h5A, "w0");
    write_data(8'hC3, "w1");
    bus_stop();
    check("w_ptr_end", rd_addr, 8'h12);
    check("w_busy_end", busy, 1'b0);

    // Directed read: pointer 0x20, repeated START, ACK then NACK.
    s_rd = rd_n;
    bus_start();
    set_ptr(8'h20, "r");
    bus_start();
    send_byte(8'hA1, ack);
    check("r_addr_ack", ack, 1'b0);
    read_data(1'b0, "r0");
    read_data(1'b1, "r1");
    tick(5);
    check("r_fab_values", {m_mem[8'h20], m_mem[8'h21]}, 16'hDFDE);
    check("r_rd_stb_cnt", rd_n - s_rd, 2);
    check("r_busy_wait", busy, 1'b0);
    check("r_ptr_end", rd_addr, 8'h22);
    bus_stop();
    check("r_busy_idle", busy, 1'b0);

    // Address miss: 0x51 must never be acknowledged or disturb anything.
    s_wr = wr_n; s_rd = rd_n; s_dr = drove_n; s_bz = busy_n;
    bus_start();
    send_byte(8'hA2, ack);
    check("miss_addr_nack", ack, 1'b1);
    send_byte(8'h00, ack);
    check("miss_data_nack", ack, 1'b1);
    bus_stop();
    check("miss_no_wr", wr_n - s_wr, 0);
    check("miss_no_rd", rd_n - s_rd, 0);
    check("miss_no_drive", drove_n - s_dr, 0);
    check("miss_no_busy", busy_n - s_bz, 0);
    check("miss_ptr", rd_addr, m_ptr);

    // Pointer wrap across 0xFF.
    bus_start();
    set_ptr(8'hFF, "wrap");
    write_data(8'h11, "wrap0");
    write_data(8'h22, "wrap1");
    bus_stop();
    check("wrap_ptr", rd_addr, 8'h01);

    // Randomized write-then-readback rounds.
    for (int r = 0; r < 3; r++) begin
      p = 8'($urandom);
      n = $urandom_range(3, 1);
      bus_start();
      set_ptr(p, "rw");
      for (int j = 0; j < n; j++) write_data(8'($urandom), "rw");
      bus_stop();
      check("rw_ptr_after_wr", rd_addr, m_ptr);
      bus_start();
      set_ptr(p, "rb");
      bus_start();
      send_byte(8'hA1, ack);
      check("rb_addr_ack", ack, 1'b0);
      for (int j = 0; j < n; j++) read_data(j == n - 1, "rb");
      bus_stop();
      check("rb_ptr_after_rd", rd_addr, m_ptr);
    end

    // Reset while the target holds the data-byte ACK low.
    bus_start();
    set_ptr(8'h40, "ra");
    d = 8'($urandom);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    tick(1);
    m_low = 1'b0;
    k = 0;
    while (sda !== 1'b0 && k < 20) begin
      tick(1);
      k++;
    end
    check("ra_ack_driven", sda, 1'b0);
    reset = 1'b1;
    tick(1);
    check("ra_sda_released", sda, 1'b1);
    check("ra_busy", busy, 1'b0);
    check("ra_ptr_reset", rd_addr, 8'h00);
    wr_exp++;
    check("ra_wr_entry", wr_log[wr_exp-1], {8'h40, d});
    m_mem[8'h40] = d;
    m_ptr = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(5);
    bus_start();
    send_byte(8'hA0, ack);
    check("ra_readdr_ack", ack, 1'b0);
    check("ra_busy_again", busy, 1'b1);
    bus_stop();
    check("ra_busy_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
